// File: rtl/vga_fill_master.sv
// APB initiator that fills a clipped rectangle of the 640x480 frame buffer with one colour.
// Define VGA_FILL_TIMEOUT_EN to abandon a fill when a transfer stalls for TIMEOUT cycles.
module vga_fill_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [23:0] cmd_color,
  output logic        done,
  output logic        err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [2:0]  out_pprot,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata
);

  localparam logic [31:0] FB_BASE    = 32'h2100_0000;
  localparam logic [9:0]  H_RES      = 10'd640;
  localparam logic [9:0]  V_RES      = 10'd480;
  localparam logic [31:0] ROW_STRIDE = 32'd2560;
`ifdef VGA_FILL_TIMEOUT_EN
  localparam logic [7:0]  TIMEOUT    = 8'd255;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [9:0]  w_last;
  logic [9:0]  h_last;
  logic [31:0] row_base;
`ifdef VGA_FILL_TIMEOUT_EN
  logic [7:0]  stall_cnt;
`endif

  logic [9:0]  x_room;
  logic [9:0]  y_room;
  logic [9:0]  w_eff;
  logic [9:0]  h_eff;
  logic        empty;
  logic [31:0] pix_index;
  logic [31:0] start_addr;
  logic        last_pixel;
  logic        unused_prdata;

  assign out_pprot     = 3'b000;
  assign out_pstrb     = 4'hF;
  assign unused_prdata = ^out_prdata;

  // Clipped size and start address of the offered command; room values are
  // meaningless for off-screen corners, but those commands are empty anyway.
  always_comb begin
    x_room     = H_RES - cmd_x0;
    y_room     = V_RES - cmd_y0;
    w_eff      = (cmd_w < x_room) ? cmd_w : x_room;
    h_eff      = (cmd_h < y_room) ? cmd_h : y_room;
    empty      = (cmd_x0 >= H_RES) || (cmd_y0 >= V_RES) || (cmd_w == 10'd0) || (cmd_h == 10'd0);
    pix_index  = ({22'd0, cmd_y0} << 9) + ({22'd0, cmd_y0} << 7) + {22'd0, cmd_x0};
    start_addr = FB_BASE + (pix_index << 2);
    last_pixel = (col == w_last) && (row == h_last);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      out_paddr   <= 32'd0;
      out_pwdata  <= 32'd0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pwrite  <= 1'b0;
      col         <= 10'd0;
      row         <= 10'd0;
      w_last      <= 10'd0;
      h_last      <= 10'd0;
      row_base    <= 32'd0;
`ifdef VGA_FILL_TIMEOUT_EN
      stall_cnt   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            err        <= 1'b0;
            col        <= 10'd0;
            row        <= 10'd0;
            w_last     <= w_eff - 10'd1;
            h_last     <= h_eff - 10'd1;
            row_base   <= start_addr;
            out_paddr  <= start_addr;
            out_pwdata <= {8'h00, cmd_color};
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= SETUP;
              out_psel   <= 1'b1;
              out_pwrite <= 1'b1;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          out_penable <= 1'b1;
`ifdef VGA_FILL_TIMEOUT_EN
          stall_cnt   <= 8'd0;
`endif
        end
        ACCESS: begin
          if (out_pready) begin
            if (out_pslverr) err <= 1'b1;
            out_penable <= 1'b0;
            if (last_pixel) begin
              state      <= DONE;
              done       <= 1'b1;
              out_psel   <= 1'b0;
              out_pwrite <= 1'b0;
            end else begin
              state <= SETUP;
              // Row wrap restarts the address from the next row's base.
              if (col == w_last) begin
                col       <= 10'd0;
                row       <= row + 10'd1;
                row_base  <= row_base + ROW_STRIDE;
                out_paddr <= row_base + ROW_STRIDE;
              end else begin
                col       <= col + 10'd1;
                out_paddr <= out_paddr + 32'd4;
              end
            end
          end
`ifdef VGA_FILL_TIMEOUT_EN
          else if (stall_cnt == TIMEOUT - 8'd1) begin
            state       <= DONE;
            done        <= 1'b1;
            err         <= 1'b1;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwrite  <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
